// File: rtl/calculator_input_if.sv
// Bundle of raw board inputs and conditioned outputs between the board
// switches/button and the calculator_input conditioning stage.
interface calculator_input_if;
    logic       button;
    logic [2:0] func;
    logic [7:0] num1;
    logic [7:0] num2;
    logic       cmd_valid;
    logic [2:0] func_q;
    logic [7:0] num1_q;
    logic [7:0] num2_q;
    logic       btn_level;
    logic [7:0] press_cnt;

    // Board side: drives the raw switches and observes the clean outputs.
    modport master (
        output button, func, num1, num2,
        input  cmd_valid, func_q, num1_q, num2_q, btn_level, press_cnt
    );

    // Conditioning stage side.
    modport slave (
        input  button, func, num1, num2,
        output cmd_valid, func_q, num1_q, num2_q, btn_level, press_cnt
    );
endinterface

// File: rtl/calculator_input.sv
// Input conditioning for the hex calculator: synchronises the raw switches,
// debounces the push button and, on each accepted press, emits a one-cycle
// cmd_valid strobe together with a frozen operand/function snapshot.
module calculator_input #(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input logic               clk_g,
    input logic               rst,
    calculator_input_if.slave bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } state_t;

    // Two-flop synchroniser chains; only the *_s_q copies feed the logic.
    logic       b_m_q, b_s_q;
    logic [2:0] func_m_q, func_s_q;
    logic [7:0] n1_m_q, n1_s_q;
    logic [7:0] n2_m_q, n2_s_q;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    logic       cmd_valid_q;
    logic [2:0] func_cap_q;
    logic [7:0] num1_cap_q;
    logic [7:0] num2_cap_q;
    logic       btn_level_q;
    logic [7:0] press_cnt_q;

    // Bring the asynchronous board inputs into the clk_g domain.
    always_ff @(posedge clk_g) begin
        if (rst) begin
            b_m_q    <= 1'b0;
            b_s_q    <= 1'b0;
            func_m_q <= '0;
            func_s_q <= '0;
            n1_m_q   <= '0;
            n1_s_q   <= '0;
            n2_m_q   <= '0;
            n2_s_q   <= '0;
        end else begin
            b_m_q    <= bus.button;
            b_s_q    <= b_m_q;
            func_m_q <= bus.func;
            func_s_q <= func_m_q;
            n1_m_q   <= bus.num1;
            n1_s_q   <= n1_m_q;
            n2_m_q   <= bus.num2;
            n2_s_q   <= n2_m_q;
        end
    end

    // Debounce FSM state and shared stability counter.
    always_ff @(posedge clk_g) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: a level change is accepted only after it has been
    // seen for DEBOUNCE_CYCLES+1 consecutive synchronised samples.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (b_s_q) begin
                    state_d = PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            PRESS_CHK: begin
                if (!b_s_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = HELD;
                    accept  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!b_s_q) begin
                    state_d = REL_CHK;
                    cnt_d   = '0;
                end
            end
            REL_CHK: begin
                if (b_s_q) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs: strobe and snapshot on the accept edge only,
    // debounced level follows the state being entered.
    always_ff @(posedge clk_g) begin
        if (rst) begin
            cmd_valid_q <= 1'b0;
            func_cap_q  <= '0;
            num1_cap_q  <= '0;
            num2_cap_q  <= '0;
            btn_level_q <= 1'b0;
            press_cnt_q <= '0;
        end else begin
            cmd_valid_q <= accept;
            btn_level_q <= (state_d == HELD) || (state_d == REL_CHK);
            if (accept) begin
                func_cap_q  <= func_s_q;
                num1_cap_q  <= n1_s_q;
                num2_cap_q  <= n2_s_q;
                press_cnt_q <= press_cnt_q + 8'd1;
            end
        end
    end

    assign bus.cmd_valid = cmd_valid_q;
    assign bus.func_q    = func_cap_q;
    assign bus.num1_q    = num1_cap_q;
    assign bus.num2_q    = num2_cap_q;
    assign bus.btn_level = btn_level_q;
    assign bus.press_cnt = press_cnt_q;
endmodule

// File: tb/tb_calculator_input.sv
// Bench for calculator_input: directed scenarios plus randomized button
// activity, checked every cycle against a run-length reference model.
module tb_calculator_input;
    localparam int D = 4;

    logic clk_g = 1'b0;
    logic rst   = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   strobes = 0;

    calculator_input_if bus();

    calculator_input #(.DEBOUNCE_CYCLES(D)) u_dut (
        .clk_g (clk_g),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clk_g = ~clk_g;

    // Reference model: two-sample delay, then a level flips once the
    // opposite value has been seen D+1 samples in a row.
    logic       h1_b, h2_b;
    logic [2:0] h1_f, h2_f;
    logic [7:0] h1_n1, h2_n1, h1_n2, h2_n2;
    logic       m_level, m_valid;
    int         m_run;
    logic [2:0] m_func;
    logic [7:0] m_n1, m_n2, m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            h1_b = 0; h2_b = 0; h1_f = 0; h2_f = 0;
            h1_n1 = 0; h2_n1 = 0; h1_n2 = 0; h2_n2 = 0;
            m_level = 0; m_valid = 0; m_run = 0;
            m_func = 0; m_n1 = 0; m_n2 = 0; m_cnt = 0;
        end else begin
            m_valid = 0;
            if (h2_b != m_level) begin
                m_run++;
                if (m_run == D + 1) begin
                    m_level = h2_b;
                    m_run = 0;
                    if (h2_b) begin
                        m_valid = 1;
                        m_func = h2_f;
                        m_n1 = h2_n1;
                        m_n2 = h2_n2;
                        m_cnt = m_cnt + 8'd1;
                    end
                end
            end else begin
                m_run = 0;
            end
            h2_b = h1_b; h2_f = h1_f; h2_n1 = h1_n1; h2_n2 = h1_n2;
            h1_b = bus.button; h1_f = bus.func; h1_n1 = bus.num1; h1_n2 = bus.num2;
        end
    endtask

    task automatic cyc();
        @(posedge clk_g);
        model_step();
        #1;
        check("cmd_valid", 32'(bus.cmd_valid), 32'(m_valid));
        check("btn_level", 32'(bus.btn_level), 32'(m_level));
        check("func_q", 32'(bus.func_q), 32'(m_func));
        check("num1_q", 32'(bus.num1_q), 32'(m_n1));
        check("num2_q", 32'(bus.num2_q), 32'(m_n2));
        check("press_cnt", 32'(bus.press_cnt), 32'(m_cnt));
        if (bus.cmd_valid === 1'b1) strobes++;
    endtask

    task automatic run_until_strobe(input int maxc, output int n);
        n = 0;
        for (int i = 1; i <= maxc; i++) begin
            cyc();
            if (bus.cmd_valid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int s0;
        logic [7:0] c0;
        logic pat [5];

        bus.button = 0; bus.func = 0; bus.num1 = 0; bus.num2 = 0;

        // Reset values
        rst = 1;
        repeat (3) cyc();
        check("rst_cmd_valid", 32'(bus.cmd_valid), 0);
        check("rst_btn_level", 32'(bus.btn_level), 0);
        check("rst_func_q", 32'(bus.func_q), 0);
        check("rst_num1_q", 32'(bus.num1_q), 0);
        check("rst_num2_q", 32'(bus.num2_q), 0);
        check("rst_press_cnt", 32'(bus.press_cnt), 0);
        rst = 0;
        repeat (6) cyc();

        // Clean press: strobe D+2 edges after the first high sample
        bus.func = 3'b010; bus.num1 = 8'h3C; bus.num2 = 8'h05;
        repeat (2) cyc();
        bus.button = 1;
        s0 = strobes;
        run_until_strobe(20, n);
        check("clean_latency", 32'(n), 32'(D + 3));
        check("clean_func_q", 32'(bus.func_q), 2);
        check("clean_num1_q", 32'(bus.num1_q), 32'h3C);
        check("clean_num2_q", 32'(bus.num2_q), 32'h05);
        check("clean_press_cnt", 32'(bus.press_cnt), 1);
        check("clean_btn_level", 32'(bus.btn_level), 1);
        repeat (10) cyc();
        check("clean_one_strobe", 32'(strobes - s0), 1);
        bus.button = 0;
        repeat (D + 6) cyc();
        check("clean_released", 32'(bus.btn_level), 0);

        // Bouncing press: 1,0,1,1,0 then hold high
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        s0 = strobes;
        c0 = bus.press_cnt;
        for (int i = 0; i < 5; i++) begin
            bus.button = pat[i];
            cyc();
        end
        bus.button = 1;
        run_until_strobe(20, n);
        check("bounce_latency", 32'(n), 32'(D + 3));
        repeat (8) cyc();
        check("bounce_one_strobe", 32'(strobes - s0), 1);
        check("bounce_press_cnt", 32'(bus.press_cnt), 32'(c0 + 8'd1));

        // Release bounce while held, operands must not follow the switches
        s0 = strobes;
        bus.button = 0;
        repeat (2) cyc();
        bus.button = 1;
        bus.num1 = 8'hFF;
        repeat (12) cyc();
        check("relbounce_no_strobe", 32'(strobes - s0), 0);
        check("relbounce_level", 32'(bus.btn_level), 1);
        check("relbounce_num1_hold", 32'(bus.num1_q), 32'h3C);
        bus.button = 0;
        repeat (D + 6) cyc();

        // Reset in PRESS_CHK with cnt = 2: no strobe
        s0 = strobes;
        bus.button = 1;
        repeat (5) cyc();
        rst = 1;
        bus.button = 0;
        repeat (2) cyc();
        rst = 0;
        repeat (D + 6) cyc();
        check("rst_presschk_no_strobe", 32'(strobes - s0), 0);
        check("rst_presschk_cnt", 32'(bus.press_cnt), 0);

        // Reset while HELD, button kept high through reset release
        bus.func = 3'b101; bus.num1 = 8'hA7; bus.num2 = 8'h19;
        bus.button = 1;
        repeat (D + 5) cyc();
        check("held_before_rst", 32'(bus.btn_level), 1);
        rst = 1;
        repeat (2) cyc();
        check("rst_held_level", 32'(bus.btn_level), 0);
        check("rst_held_num1", 32'(bus.num1_q), 0);
        check("rst_held_func", 32'(bus.func_q), 0);
        check("rst_held_cnt", 32'(bus.press_cnt), 0);
        rst = 0;
        run_until_strobe(20, n);
        check("rst_held_relatency", 32'(n), 32'(D + 3));
        check("rst_held_num1_cap", 32'(bus.num1_q), 32'hA7);
        bus.button = 0;
        repeat (D + 6) cyc();

        // Randomized button activity with occasional resets
        for (int s = 0; s < 150; s++) begin
            bus.button = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
                bus.func = 3'($urandom);
                bus.num1 = 8'($urandom);
                bus.num2 = 8'($urandom);
            end
            rst = ($urandom_range(0, 39) == 0);
            repeat ($urandom_range(1, 9)) cyc();
            rst = 0;
        end
        bus.button = 0;
        repeat (D + 6) cyc();

        // Wrap-around: 256 clean presses from reset
        rst = 1;
        repeat (2) cyc();
        rst = 0;
        repeat (2) cyc();
        s0 = strobes;
        for (int p = 0; p < 256; p++) begin
            bus.num1 = 8'(p);
            bus.button = 1;
            repeat (D + 4) cyc();
            bus.button = 0;
            repeat (D + 4) cyc();
        end
        check("wrap_strobes", 32'(strobes - s0), 256);
        check("wrap_press_cnt", 32'(bus.press_cnt), 0);
        check("wrap_last_num1", 32'(bus.num1_q), 32'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/calculator_input.md
# calculator_input

Input-conditioning stage sitting directly upstream of `calculator_hex` in the hex calculator design, clocked by the divided clock `clk_g`. It synchronises the raw `button`, `func`, `num1` and `num2` board inputs and debounces `button` with a four-state FSM. On each accepted press it captures a stable operand/function snapshot and issues a single-cycle `cmd_valid` strobe. `calculator_hex` and `calculator_display` consume the clean strobe and the frozen operands instead of raw switch levels.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 20000: consecutive stable `clk_g` cycles required to accept a press or a release. Legal range ≥ 2; benches override it to a small value.

Ports:
- `clk_g`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `button`  in  1  raw, asynchronous, bouncing push button; high = pressed.
- `func`  in  3  raw function-select switches.
- `num1`  in  8  raw operand 1 switches.
- `num2`  in  8  raw operand 2 switches.
- `cmd_valid`  out  1  one-cycle strobe per accepted press.
- `func_q`  out  3  function captured at the last accepted press.
- `num1_q`  out  8  operand 1 captured at the last accepted press.
- `num2_q`  out  8  operand 2 captured at the last accepted press.
- `btn_level`  out  1  debounced button level.
- `press_cnt`  out  8  count of accepted presses; wraps 255 → 0.

## Operation
- **Synchronisers:** `button`, `func`, `num1` and `num2` each pass through 2-flop synchronisers. Call the synchronised signals `b_s`, `func_s`, `n1_s` and `n2_s`. All logic below uses only these synchronised copies.
- **FSM states:** IDLE, PRESS_CHK, HELD, REL_CHK. A single counter `cnt` (width ceil(log2(DEBOUNCE_CYCLES)) bits) serves both check states.
- **IDLE:**
  - `b_s` = 1 → PRESS_CHK, `cnt` ← 0.
  - Otherwise stay in IDLE.
- **PRESS_CHK:**
  - `b_s` = 0 → IDLE (bounce rejected; no strobe).
  - `b_s` = 1 and `cnt` = DEBOUNCE_CYCLES−1 → HELD.
  - Otherwise `cnt` ← `cnt`+1.
- **HELD:**
  - `b_s` = 0 → REL_CHK, `cnt` ← 0.
  - Otherwise stay in HELD.
- **REL_CHK:**
  - `b_s` = 1 → HELD (release bounce rejected; no new strobe).
  - `b_s` = 0 and `cnt` = DEBOUNCE_CYCLES−1 → IDLE.
  - Otherwise `cnt` ← `cnt`+1.
- **Accept edge:** on the PRESS_CHK → HELD edge, all of the following happen at that same edge:
  - `cmd_valid` ← 1;
  - `func_q` ← `func_s`, `num1_q` ← `n1_s`, `num2_q` ← `n2_s`;
  - `press_cnt` ← `press_cnt`+1, modulo 256.
- **Strobe width:** `cmd_valid` is high for exactly one cycle per press, regardless of how long the button is held.
- **Operand hold:** `func_q`, `num1_q` and `num2_q` hold their values between presses. Switch changes while in HELD, REL_CHK or IDLE have no effect on them.
- **Debounced level:** `btn_level` = 1 in HELD and REL_CHK, 0 in IDLE and PRESS_CHK. It is a registered output derived from the state.
- **Reset:** `rst` has priority over all other behaviour, including mid-count and mid-hold. Reset returns the FSM to IDLE and clears `cnt`, both synchroniser chains, and every output.
- **Holding button through reset:** if the button is held while `rst` deasserts, the block re-enters PRESS_CHK and issues one strobe after the full debounce interval.

## Timing
- **Output reset values:** `cmd_valid`=0, `func_q`=0, `num1_q`=0, `num2_q`=0, `btn_level`=0, `press_cnt`=0.
- **Press latency:** `button` is first sampled high at edge k and then held stable.
  - `b_s` = 1 after edge k+1.
  - PRESS_CHK is entered at edge k+2.
  - `cmd_valid` and `btn_level` go high after edge k+DEBOUNCE_CYCLES+2.
  - `cmd_valid` falls after edge k+DEBOUNCE_CYCLES+3.
- **Operand sampling point:** the captured operands are the switch values sampled at edge k+DEBOUNCE_CYCLES; they pass through the 2-cycle synchroniser.
- **Release latency:** `button` is first sampled low at edge r. `btn_level` falls after edge r+DEBOUNCE_CYCLES+2.
- **Bounce rejection:** any `b_s` pulse shorter than DEBOUNCE_CYCLES+1 cycles produces no strobe.
- **Minimum press period:** one accepted press per 2·(DEBOUNCE_CYCLES+1) cycles.

## Test plan
- **Reset values:** assert `rst` for 3 cycles → all outputs 0 and the FSM is in IDLE.
- **Clean press (DEBOUNCE_CYCLES=4):** set `func`=3'b010, `num1`=8'h3C, `num2`=8'h05, then raise `button` at edge 10 and hold → `cmd_valid` high for one cycle after edge 16; `func_q`=2, `num1_q`=8'h3C, `num2_q`=8'h05; `press_cnt`=1; `btn_level`=1.
- **Bouncing press (DEBOUNCE_CYCLES=4):** drive `button` 1,0,1,1,0 over consecutive cycles, then hold 1 → exactly one strobe, occurring 6 cycles after the final rising sample; `press_cnt` increments by 1.
- **Release bounce and operand hold:** while in HELD, drop `button` for 2 cycles, then return it high, and change `num1` to 8'hFF → no new strobe; `btn_level` stays 1; `num1_q` is unchanged.
- **Wrap-around:** 256 clean presses → `press_cnt` returns to 0; 256 strobes are counted.
- **Reset mid-operation:** assert `rst` in PRESS_CHK with `cnt`=2 → no strobe. Assert `rst` in HELD → `btn_level`=0 and operands cleared. Keep the button held after `rst` deasserts → one strobe after DEBOUNCE_CYCLES+2 cycles.
